jtdsp16_loop_ctrl: RTL and testbench

Loop sequencer for the DSP16 `do`/`redo` instruction cache. It sits between the instruction decoder and the ROM address arithmetic unit (XAAU).
- On `do`, it records the following NI instructions from ROM into a 15-entry cache.
- It then replays the cached block K−1 more times. While replaying it holds the program counter with `pc_halt` and steers the instruction bus to the cache.
- `redo` replays the last cached block K times without refetching.

---
 rtl/jtdsp16_loop_ctrl.sv | 140 ++++++++++++++
 tb/tb_jtdsp16_loop_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtdsp16_loop_ctrl.sv
// rtl/jtdsp16_loop_ctrl.sv - DSP16 do/redo loop sequencer with 15-word instruction cache
//
// Records the NI-word body that follows a `do K` into a small cache while it
// executes from ROM. It then replays that body K-1 more times from the cache.
// `redo K` replays the last recorded body K times.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   cen               clock enable, gates every state change
//   do_start, redo    decoded instructions, sampled on cen cycles
//   ni_field[3:0]     body length NI (0 makes do_start a no-op)
//   k_field[6:0]      iteration count K
//   rom_dout[15:0]    ROM instruction word, captured during FILL
//   pc_halt           holds the XAAU program counter during REPLAY
//   inst_sel          1 = decoder takes cache_dout
//   cache_dout[15:0]  cached word during REPLAY, else 0
//   busy              FILL or REPLAY in progress
//   k_left[6:0]       remaining replay passes
module jtdsp16_loop_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        do_start,
  input  logic        redo,
  input  logic [3:0]  ni_field,
  input  logic [6:0]  k_field,
  input  logic [15:0] rom_dout,
  output logic        pc_halt,
  output logic        inst_sel,
  output logic [15:0] cache_dout,
  output logic        busy,
  output logic [6:0]  k_left
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    REPLAY = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  ni_r, ni_nxt;
  logic [3:0]  wr_ptr, wr_nxt;
  logic [3:0]  rd_ptr, rd_nxt;
  logic [6:0]  k_cnt, k_nxt;
  logic        cache_valid, valid_nxt;
  logic        cache_we;
  logic [3:0]  last_idx;

  // No reset on the storage so it can map onto a RAM.
  logic [15:0] cache [0:14];

  // ni_r is never 0 outside IDLE, so this never wraps when it is used.
  assign last_idx = ni_r - 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ni_r        <= 4'd0;
      wr_ptr      <= 4'd0;
      rd_ptr      <= 4'd0;
      k_cnt       <= 7'd0;
      cache_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      ni_r        <= ni_nxt;
      wr_ptr      <= wr_nxt;
      rd_ptr      <= rd_nxt;
      k_cnt       <= k_nxt;
      cache_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ni_nxt    = ni_r;
    wr_nxt    = wr_ptr;
    rd_nxt    = rd_ptr;
    k_nxt     = k_cnt;
    valid_nxt = cache_valid;
    cache_we  = 1'b0;
    if (cen) begin
      case (state)
        IDLE: begin
          // do_start has priority over a simultaneous redo.
          if (do_start && ni_field != 4'd0) begin
            state_nxt = FILL;
            ni_nxt    = ni_field;
            wr_nxt    = 4'd0;
            // The ROM pass counts as the first iteration.
            k_nxt     = (k_field >= 7'd2) ? k_field - 7'd1 : 7'd0;
            valid_nxt = 1'b0;
          end else if (redo && k_field != 7'd0 && cache_valid) begin
            state_nxt = REPLAY;
            rd_nxt    = 4'd0;
            k_nxt     = k_field;
          end
        end
        FILL: begin
          cache_we = 1'b1;
          if (wr_ptr == last_idx) begin
            wr_nxt    = 4'd0;
            valid_nxt = 1'b1;
            if (k_cnt != 7'd0) begin
              state_nxt = REPLAY;
              rd_nxt    = 4'd0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            wr_nxt = wr_ptr + 4'd1;
          end
        end
        REPLAY: begin
          if (rd_ptr != last_idx) begin
            rd_nxt = rd_ptr + 4'd1;
          end else begin
            rd_nxt = 4'd0;
            // REPLAY is only entered with k_cnt >= 1; the guard keeps it from wrapping.
            k_nxt  = (k_cnt != 7'd0) ? k_cnt - 7'd1 : 7'd0;
            if (k_cnt <= 7'd1) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cache_we) cache[wr_ptr] <= rom_dout;
  end

  // Outputs decode straight from state so that reset clears them immediately.
  assign pc_halt    = (state == REPLAY);
  assign inst_sel   = (state == REPLAY);
  assign busy       = (state != IDLE);
  assign k_left     = k_cnt;
  assign cache_dout = (state == REPLAY) ? cache[rd_ptr] : 16'h0000;

endmodule

// File: tb/tb_jtdsp16_loop_ctrl.sv
// tb/tb_jtdsp16_loop_ctrl.sv - scoreboard testbench for jtdsp16_loop_ctrl
module tb_jtdsp16_loop_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic        do_start = 1'b0;
  logic        redo = 1'b0;
  logic [3:0]  ni_field = 4'd0;
  logic [6:0]  k_field = 7'd0;
  logic [15:0] rom_dout = 16'h0000;
  logic        pc_halt, inst_sel, busy;
  logic [15:0] cache_dout;
  logic [6:0]  k_left;

  jtdsp16_loop_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .do_start   (do_start),
    .redo       (redo),
    .ni_field   (ni_field),
    .k_field    (k_field),
    .rom_dout   (rom_dout),
    .pc_halt    (pc_halt),
    .inst_sel   (inst_sel),
    .cache_dout (cache_dout),
    .busy       (busy),
    .k_left     (k_left)
  );

  always #5 clk = ~clk;

  // Observed vector: {pc_halt, inst_sel, busy, k_left, cache_dout}
  logic [25:0] obs;
  assign obs = {pc_halt, inst_sel, busy, k_left, cache_dout};

  typedef struct {
    logic        ds;
    logic        rd;
    logic        ce;
    logic [3:0]  ni;
    logic [6:0]  k;
    logic [15:0] rom;
    logic [25:0] exp;
  } ent_t;

  ent_t        q[$];
  ent_t        e;
  logic [15:0] words [15];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [25:0] ob(input logic ph, input logic is, input logic b,
                                     input int kl, input logic [15:0] d);
    return {ph, is, b, 7'(kl), d};
  endfunction

  function automatic logic [25:0] idle_ob();
    return 26'd0;
  endfunction

  task automatic push(input logic ds, input logic rd, input logic ce, input int ni,
                      input int k, input logic [15:0] rom, input logic [25:0] exp);
    ent_t t;
    t.ds = ds; t.rd = rd; t.ce = ce; t.ni = 4'(ni); t.k = 7'(k); t.rom = rom; t.exp = exp;
    q.push_back(t);
  endtask

  // One entry per cen cycle starting with the cycle where do_start is sampled.
  // Entry m's expectation is what the outputs show right after edge m.
  task automatic push_do(input int n, input int k, input logic with_redo);
    int reps = (k >= 2) ? k - 1 : 0;
    int kl0  = (k >= 2) ? k - 1 : 0;
    int len  = n + reps * n + 1;
    for (int m = 0; m < len; m++) begin
      logic [25:0] x;
      logic [15:0] rom = (m >= 1 && m <= n) ? words[m-1] : 16'h0000;
      if (m < n) x = ob(0, 0, 1, kl0, 16'h0000);
      else if (m < n + reps * n) x = ob(1, 1, 1, k - 1 - (m - n) / n, words[(m - n) % n]);
      else x = idle_ob();
      push(m == 0, (m == 0) && with_redo, 1'b1, n, k, rom, x);
    end
  endtask

  task automatic push_redo(input int n, input int k);
    for (int m = 0; m <= n * k; m++) begin
      logic [25:0] x;
      if (m < n * k) x = ob(1, 1, 1, k - m / n, words[m % n]);
      else x = idle_ob();
      push(1'b0, m == 0, 1'b1, 0, k, 16'h0000, x);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (obs !== idle_ob()) begin
      miscompares++;
      $display("FAIL reset: got %h want %h", obs, idle_ob());
    end
    rst = 1'b0;
  endtask

  task automatic test_ignored_cmds();
    push(1'b0, 1'b1, 1'b1, 3, 2, 16'h0, idle_ob());  // redo before any do
    push(1'b0, 1'b0, 1'b1, 0, 0, 16'h0, idle_ob());
    push(1'b1, 1'b0, 1'b1, 0, 5, 16'h0, idle_ob());  // do with NI=0
    push(1'b0, 1'b0, 1'b1, 0, 0, 16'h0, idle_ob());
    for (int m = 0; q.size() > 0; m++) begin
      e = q.pop_front();
      do_start = e.ds; redo = e.rd; cen = e.ce; ni_field = e.ni; k_field = e.k; rom_dout = e.rom;
      @(posedge clk); #1;
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL ignored_cmds[%0d]: got %h want %h", m, obs, e.exp);
      end
    end
  endtask

  task automatic test_do_basic();
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    push_do(3, 2, 1'b0);
    for (int m = 0; q.size() > 0; m++) begin
      e = q.pop_front();
      do_start = e.ds; redo = e.rd; cen = e.ce; ni_field = e.ni; k_field = e.k; rom_dout = e.rom;
      @(posedge clk); #1;
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL do_basic[%0d]: got %h want %h", m, obs, e.exp);
      end
    end
  endtask

  task automatic test_redo();
    push_redo(3, 3);
    push(1'b0, 1'b0, 1'b1, 0, 0, 16'h0, idle_ob());
    for (int m = 0; q.size() > 0; m++) begin
      e = q.pop_front();
      do_start = e.ds; redo = e.rd; cen = e.ce; ni_field = e.ni; k_field = e.k; rom_dout = e.rom;
      @(posedge clk); #1;
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL redo[%0d]: got %h want %h", m, obs, e.exp);
      end
    end
  endtask

  task automatic test_do_k1_and_priority();
    words[0] = 16'hA001; words[1] = 16'hA002; words[2] = 16'hA003; words[3] = 16'hA004;
    push_do(4, 1, 1'b0);
    words[0] = 16'hB0B0; words[1] = 16'hC0C0;
    push_do(2, 3, 1'b1);  // do_start and redo together: do wins
    for (int m = 0; q.size() > 0; m++) begin
      e = q.pop_front();
      do_start = e.ds; redo = e.rd; cen = e.ce; ni_field = e.ni; k_field = e.k; rom_dout = e.rom;
      @(posedge clk); #1;
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL do_k1_prio[%0d]: got %h want %h", m, obs, e.exp);
      end
    end
  endtask

  task automatic test_long();
    for (int i = 0; i < 15; i++) words[i] = 16'($urandom());
    push_do(15, 127, 1'b0);
    for (int m = 0; q.size() > 0; m++) begin
      e = q.pop_front();
      do_start = e.ds; redo = e.rd; cen = e.ce; ni_field = e.ni; k_field = e.k; rom_dout = e.rom;
      @(posedge clk); #1;
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL long[%0d]: got %h want %h", m, obs, e.exp);
      end
    end
  endtask

  task automatic test_cen_stall();
    words[0] = 16'h0D01; words[1] = 16'h0D02; words[2] = 16'h0D03;
    push_do(3, 1, 1'b0);
    push(1'b0, 1'b1, 1'b1, 0, 1, 16'h0, ob(1, 1, 1, 1, words[0]));
    push(1'b0, 1'b0, 1'b0, 0, 0, 16'h0, ob(1, 1, 1, 1, words[0]));
    push(1'b0, 1'b0, 1'b1, 0, 0, 16'h0, ob(1, 1, 1, 1, words[1]));
    push(1'b1, 1'b0, 1'b0, 2, 5, 16'h0, ob(1, 1, 1, 1, words[1]));
    push(1'b1, 1'b0, 1'b1, 2, 5, 16'h0, ob(1, 1, 1, 1, words[2]));  // do while busy: ignored
    push(1'b0, 1'b0, 1'b0, 0, 0, 16'h0, ob(1, 1, 1, 1, words[2]));
    push(1'b0, 1'b0, 1'b1, 0, 0, 16'h0, idle_ob());
    push(1'b0, 1'b0, 1'b1, 0, 0, 16'h0, idle_ob());
    for (int m = 0; q.size() > 0; m++) begin
      e = q.pop_front();
      do_start = e.ds; redo = e.rd; cen = e.ce; ni_field = e.ni; k_field = e.k; rom_dout = e.rom;
      @(posedge clk); #1;
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL cen_stall[%0d]: got %h want %h", m, obs, e.exp);
      end
    end
  endtask

  task automatic test_async_reset();
    push_redo(3, 5);
    for (int m = 0; m < 4; m++) begin
      e = q.pop_front();
      do_start = e.ds; redo = e.rd; cen = e.ce; ni_field = e.ni; k_field = e.k; rom_dout = e.rom;
      @(posedge clk); #1;
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL async_rst_pre[%0d]: got %h want %h", m, obs, e.exp);
      end
    end
    q.delete();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({pc_halt, inst_sel, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_rst_now: got %b want 000", {pc_halt, inst_sel, busy});
    end
    @(negedge clk) rst = 1'b0;
    push(1'b0, 1'b1, 1'b1, 3, 2, 16'h0, idle_ob());  // cache invalidated by reset
    push(1'b0, 1'b0, 1'b1, 0, 0, 16'h0, idle_ob());
    for (int m = 0; q.size() > 0; m++) begin
      e = q.pop_front();
      do_start = e.ds; redo = e.rd; cen = e.ce; ni_field = e.ni; k_field = e.k; rom_dout = e.rom;
      @(posedge clk); #1;
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL async_rst_post[%0d]: got %h want %h", m, obs, e.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ignored_cmds();
    test_do_basic();
    test_redo();
    test_do_k1_and_priority();
    test_long();
    test_cen_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
